// File: rtl/wb_arb_pkg.sv
// Shared types and default sizing for the round-robin Wishbone master arbiter.
package wb_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    localparam int unsigned WB_ARB_NREQ     = 4;
    localparam int unsigned WB_ARB_MAX_HOLD = 64;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Rotating-priority picker: first set req at or after start, wrapping modulo NREQ.
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter  int unsigned NREQ = WB_ARB_NREQ,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic [IW-1:0]   win,
    output logic            any
);

    // Scan highest offset first so the lowest offset from start wins.
    always_comb begin
        logic [IW-1:0] pos;
        win = start;
        pos = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            pos = IW'((int'(start) + i) % int'(NREQ));
            if (req[pos]) begin
                win = pos;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/wb_arb_rr.sv
// Round-robin Wishbone master arbiter with registered index/one-hot grant.
// Optional burst-hold limit enabled by defining WB_ARB_HOLD_LIMIT_EN.
module wb_arb_rr
    import wb_arb_pkg::*;
#(
    parameter  int unsigned NREQ     = WB_ARB_NREQ,
    parameter  int unsigned MAX_HOLD = WB_ARB_MAX_HOLD,
    localparam int unsigned IW       = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [IW-1:0]   gnt_idx,
    output logic [NREQ-1:0] gnt_oh,
    output logic            gnt_vld,
    output logic            gnt_chg
);

    if (NREQ < 2 || NREQ > 16 || MAX_HOLD < 2) begin : g_param_chk
        $error("wb_arb_rr: NREQ must be 2..16 and MAX_HOLD >= 2");
    end

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   idx_d;
    logic [NREQ-1:0] oh_d;
    logic            vld_d, chg_d;
    logic [IW-1:0]   start_c, next_idx_c, win_c;
    logic            any_c, others_c, limit_c, new_c;

`ifdef WB_ARB_HOLD_LIMIT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD);
    logic [HW-1:0] hold_q, hold_d;

    assign limit_c = (hold_q == HW'(MAX_HOLD - 1));
`else
    assign limit_c = 1'b0;
`endif

    // Rotation start: parked master first when idle, next master when busy.
    assign next_idx_c = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    assign start_c    = (state_q == ARB_BUSY) ? next_idx_c : gnt_idx;
    assign others_c   = |(req & ~gnt_oh);

    wb_arb_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .start (start_c),
        .win   (win_c),
        .any   (any_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = gnt_idx;
        oh_d    = gnt_oh;
        vld_d   = gnt_vld;
        chg_d   = 1'b0;
        new_c   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_c) begin
                    state_d = ARB_BUSY;
                    new_c   = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (req[gnt_idx] && !(limit_c && others_c)) begin
                    state_d = ARB_BUSY;
                end else if (others_c) begin
                    new_c = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                    vld_d   = 1'b0;
                    oh_d    = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (new_c) begin
            idx_d = win_c;
            oh_d  = NREQ'(1) << win_c;
            vld_d = 1'b1;
            chg_d = 1'b1;
        end
    end

`ifdef WB_ARB_HOLD_LIMIT_EN
    // Counts cycles of the current grant; saturates when uncontended.
    always_comb begin
        hold_d = hold_q;
        if (new_c) begin
            hold_d = '0;
        end else if (state_q == ARB_BUSY && state_d == ARB_BUSY && !limit_c) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_idx <= '0;
            gnt_oh  <= '0;
            gnt_vld <= 1'b0;
            gnt_chg <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_idx <= idx_d;
            gnt_oh  <= oh_d;
            gnt_vld <= vld_d;
            gnt_chg <= chg_d;
        end
    end

endmodule

// File: tb/tb_wb_arb_rr.sv
// Self-checking bench for wb_arb_rr: directed scenarios plus randomized traffic
// against a behavioural model, on NREQ=4 and NREQ=3 instances.
module tb_wb_arb_rr;

`ifdef WB_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    localparam int MH = 8;

    typedef struct {
        int idx;
        bit busy;
        int hold;
        bit chg;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req4 = '0;
    logic [2:0] req3 = '0;
    logic [1:0] gnt_idx4, gnt_idx3;
    logic [3:0] gnt_oh4;
    logic [2:0] gnt_oh3;
    logic       gnt_vld4, gnt_vld3, gnt_chg4, gnt_chg3;

    int   checks = 0;
    int   errors = 0;
    mdl_t m4, m3;

    always #5 clk = ~clk;

    wb_arb_rr #(.NREQ(4), .MAX_HOLD(MH)) dut4 (
        .clk(clk), .rst(rst), .req(req4),
        .gnt_idx(gnt_idx4), .gnt_oh(gnt_oh4), .gnt_vld(gnt_vld4), .gnt_chg(gnt_chg4)
    );

    wb_arb_rr #(.NREQ(3), .MAX_HOLD(MH)) dut3 (
        .clk(clk), .rst(rst), .req(req3),
        .gnt_idx(gnt_idx3), .gnt_oh(gnt_oh3), .gnt_vld(gnt_vld3), .gnt_chg(gnt_chg3)
    );

    function automatic mdl_t mreset();
        mdl_t o;
        o.idx = 0; o.busy = 1'b0; o.hold = 0; o.chg = 1'b0;
        return o;
    endfunction

    function automatic bit has(input logic [15:0] r, input int k);
        return r[4'(k)] === 1'b1;
    endfunction

    function automatic int scan(input logic [15:0] r, input int from, input int n);
        for (int k = 0; k < n; k++) begin
            if (has(r, (from + k) % n)) return (from + k) % n;
        end
        return from;
    endfunction

    // Arbiter rules applied to one sampled request vector.
    function automatic mdl_t mstep(input mdl_t m, input logic [15:0] r, input int n);
        mdl_t o = m;
        bit any_r;
        bit others;
        any_r  = (r != 16'h0);
        others = ((r & ~(16'(1) << m.idx)) != 16'h0);
        o.chg  = 1'b0;
        if (!m.busy) begin
            if (any_r) begin
                o.busy = 1'b1; o.idx = scan(r, m.idx, n); o.chg = 1'b1; o.hold = 0;
            end
        end else if (has(r, m.idx) && !(HOLD_EN && m.hold == MH - 1 && others)) begin
            if (m.hold < MH - 1) o.hold = m.hold + 1;
        end else if (others) begin
            o.idx = scan(r, (m.idx + 1) % n, n); o.chg = 1'b1; o.hold = 0;
        end else begin
            o.busy = 1'b0;
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("dut4_idx", 32'(gnt_idx4), 32'(m4.idx));
        check("dut4_oh",  32'(gnt_oh4),  m4.busy ? (32'd1 << m4.idx) : 32'd0);
        check("dut4_vld", 32'(gnt_vld4), 32'(m4.busy));
        check("dut4_chg", 32'(gnt_chg4), 32'(m4.chg));
        check("dut3_idx", 32'(gnt_idx3), 32'(m3.idx));
        check("dut3_oh",  32'(gnt_oh3),  m3.busy ? (32'd1 << m3.idx) : 32'd0);
        check("dut3_vld", 32'(gnt_vld3), 32'(m3.busy));
        check("dut3_chg", 32'(gnt_chg3), 32'(m3.chg));
    endtask

    // Drive at negedge, model the posedge, compare at the following negedge.
    task automatic step(input logic [3:0] r4, input logic [2:0] r3);
        req4 = r4;
        req3 = r3;
        @(posedge clk);
        if (rst) begin
            m4 = mreset();
            m3 = mreset();
        end else begin
            m4 = mstep(m4, 16'(r4), 4);
            m3 = mstep(m3, 16'(r3), 3);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(4'b0, 3'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] r4;
        logic [2:0] r3;
        m4 = mreset();
        m3 = mreset();

        // Reset state
        @(negedge clk);
        check_all();
        do_reset();

        // Parked master 0 scanned first: req 0110 -> 1; holder drops -> 2
        step(4'b0110, 3'b000);
        check("t2_idx1", 32'(gnt_idx4), 32'd1);
        check("t2_oh",   32'(gnt_oh4),  32'b0010);
        step(4'b0100, 3'b000);
        check("t2_idx2", 32'(gnt_idx4), 32'd2);
        check("t2_chg",  32'(gnt_chg4), 32'd1);

        // Asynchronous reset mid-grant clears outputs before any clock edge
        #2 rst = 1'b1;
        #1;
        check("t1_vld", 32'(gnt_vld4), 32'd0);
        check("t1_oh",  32'(gnt_oh4),  32'd0);
        check("t1_idx", 32'(gnt_idx4), 32'd0);
        m4 = mreset();
        m3 = mreset();
        @(negedge clk);
        step(4'b0, 3'b0);
        rst = 1'b0;
        step(4'b0, 3'b0);
        step(4'b0, 3'b0);

        // Full contention, holder releases one cycle each grant: 0,1,2,3,0
        step(4'b1111, 3'b000);
        check("t3_first", 32'(gnt_idx4), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(4'b1111, 3'b000);
            step(4'b1111 & ~(4'b0001 << gnt_idx4), 3'b000);
            check("t3_order", 32'(gnt_idx4), 32'((k + 1) % 4));
        end
        do_reset();

        // NREQ=3 wrap from index 2 to 0, then park at 0
        step(4'b0, 3'b100);
        check("t4_idx2", 32'(gnt_idx3), 32'd2);
        step(4'b0, 3'b011);
        check("t4_wrap", 32'(gnt_idx3), 32'd0);
        step(4'b0, 3'b000);
        check("t4_park", 32'(gnt_idx3), 32'd0);
        check("t4_idle", 32'(gnt_vld3), 32'd0);
        do_reset();

        // Two persistent masters: rotate every MH cycles only with the hold limit
        for (int c = 0; c < 5 * MH; c++) begin
            step(4'b1001, 3'b000);
            check("t5_idx", 32'(gnt_idx4),
                  HOLD_EN ? (((c / MH) % 2) != 0 ? 32'd3 : 32'd0) : 32'd0);
            check("t5_chg", 32'(gnt_chg4),
                  HOLD_EN ? 32'((c % MH) == 0) : 32'(c == 0));
        end

        // Single persistent master keeps the bus indefinitely
        for (int c = 0; c < 100; c++) begin
            step(4'b0100, 3'b000);
            check("t6_idx", 32'(gnt_idx4), 32'd2);
            check("t6_chg", 32'(gnt_chg4), 32'(c == 0));
        end
        do_reset();

        // Randomized traffic with sticky requests and occasional resets
        r4 = '0;
        r3 = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r4 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r3 = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 59) == 0);
            step(r4, r3);
        end
        rst = 1'b0;
        step(4'b0, 3'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
